// File: rtl/clock_mode_ctrl.sv
// Timekeeping and set-mode controller: keeps HH:MM:SS, advances on the 1 Hz tick,
// edits fields from button pulses and blanks the hour display while editing.
module clock_mode_ctrl #(
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick1Hz,
  input  logic       btnMode,
  input  logic       btnSet,
  input  logic       btnUp,
  input  logic       toggleAP,
  input  logic       toggleLZ,
  output logic [6:0] finalHH,
  output logic [6:0] finalMM,
  output logic [6:0] finalSS,
  output logic       showAP,
  output logic       leadingZero,
  output logic [1:0] editField
);

  localparam int unsigned CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } modeState_t;

  modeState_t state, stateNext;

  logic [4:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [CW-1:0] blinkCnt;
  logic          blinkHidden;
  logic          upAccept;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (btnSet && state != RUN) begin
      stateNext = RUN;
    end else if (btnMode) begin
      case (state)
        RUN:     stateNext = SET_HH;
        SET_HH:  stateNext = SET_MM;
        SET_MM:  stateNext = SET_SS;
        SET_SS:  stateNext = RUN;
        default: stateNext = RUN;
      endcase
    end
  end

  // A btnUp only counts when the state stays put, so a mode change drops it.
  assign upAccept = btnUp && (state != RUN) && (stateNext == state);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (state == RUN) begin
      if (tick1Hz) begin
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == 6'd59) begin
            minutes <= '0;
            hours   <= (hours == 5'd23) ? '0 : hours + 5'd1;
          end else begin
            minutes <= minutes + 6'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end
    end else if (upAccept) begin
      case (state)
        SET_HH:  hours   <= (hours == 5'd23)   ? '0 : hours + 5'd1;
        SET_MM:  minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
        SET_SS:  seconds <= (seconds == 6'd59) ? '0 : seconds + 6'd1;
        default: ;
      endcase
    end
  end

  // Blink restarts visible on entry to any edit state and after each accepted increment.
  always_ff @(posedge clk) begin
    if (!reset_n || stateNext == RUN) begin
      blinkCnt    <= '0;
      blinkHidden <= 1'b0;
    end else if (stateNext != state || upAccept) begin
      blinkCnt    <= '0;
      blinkHidden <= 1'b0;
    end else if (blinkCnt == BLINK_LAST) begin
      blinkCnt    <= '0;
      blinkHidden <= ~blinkHidden;
    end else begin
      blinkCnt <= blinkCnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      showAP      <= 1'b0;
      leadingZero <= 1'b0;
    end else begin
      if (toggleAP) showAP      <= ~showAP;
      if (toggleLZ) leadingZero <= ~leadingZero;
    end
  end

  always_comb begin
    finalHH   = {2'b00, hours};
    if (state != RUN && blinkHidden) finalHH = '1;
    finalMM   = {1'b0, minutes};
    finalSS   = {1'b0, seconds};
    editField = state;
  end

endmodule
